fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch stage of the MIPS pipeline. It owns the program counter and the IF/ID pipeline register, and feeds the 32-bit adder for both PC+4 and the branch-target sum. It selects the next PC from four sources (sequential, branch, jump, jump-register) under stall and flush control. Instruction memory is asynchronous-read, so the instruction is returned in the same cycle its address is presented.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction placed in IF/ID on flush or reset (sll $0,$0,0).

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
stall_i  input  1  hazard unit stall; freezes PC and IF/ID.
flush_i  input  1  squash the IF/ID contents (exception/external).
branch_taken_i  input  1  ID-stage branch resolved taken.
branch_offset_i  input  32  sign-extended 16-bit immediate from ID (word offset).
jump_i  input  1  ID-stage J/JAL.
jump_index_i  input  26  instr[25:0] of the jump in ID.
jr_i  input  1  ID-stage JR/JALR.
jr_addr_i  input  32  rs value for JR.
imem_addr_o  output  32  current PC to instruction memory.
imem_rdata_i  input  32  instruction word at imem_addr_o (same cycle).
if_id_pc4_o  output  32  registered PC+4 of the instruction in ID.
if_id_instr_o  output  32  registered instruction in ID.
if_id_valid_o  output  1  IF/ID holds a real instruction.
branch_target_o  output  32  if_id_pc4_o + (branch_offset_i << 2), for debug and JAL link checks.
misalign_o  output  1  registered one-cycle pulse when a JR address has bits [1:0] != 0.

Behaviour:
- Reset (reset_n=0, asynchronous): pc=RESET_PC, if_id_pc4_o=0, if_id_instr_o=NOP_WORD, if_id_valid_o=0, misalign_o=0. Reset mid-operation discards any pending redirect.
- imem_addr_o = pc (combinational). pc4 = pc + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000 and the carry is discarded.
- Branch target = if_id_pc4_o + {branch_offset_i[29:0], 2'b00}, modulo 2^32 (negative offsets wrap).
- Jump target = {if_id_pc4_o[31:28], jump_index_i, 2'b00}.
- JR target = {jr_addr_i[31:2], 2'b00}. misalign_o pulses on the next edge if jr_i is taken and jr_addr_i[1:0] != 0.
- Next-PC priority, evaluated each edge:
  1. stall_i: hold PC and IF/ID. Redirect inputs are ignored; ID holds, so they re-present next cycle.
  2. jr_i
  3. jump_i
  4. branch_taken_i
  5. sequential pc4
- Redirect taken (any of 2–4, not stalled): pc<=target; IF/ID <= {pc4, NOP_WORD, valid=0}. This is a one-cycle bubble (wrong-path instruction squashed).
- Sequential, not stalled: IF/ID <= {pc4, imem_rdata_i, valid=1}.
- flush_i: IF/ID <= NOP, valid=0, regardless of stall. PC still follows the priority list, and flush plus stall keeps PC held.
- Multiple redirect flags asserted together: the priority above applies; no error is raised.
- Latency: instruction at PC N appears on if_id_instr_o one edge after PC=N. The first valid IF/ID occurs one edge after reset release.
- The adder is ripple gate-level, about 3.2 ns worst case. The bench clock period must be ≥ 5000 ps (timescale 1 ps / 100 fs), and outputs are sampled just before the edge.

Decomposition:
- Shared package/header (mips_defs):
  - RESET_PC default
  - NOP_WORD
  - PC_STEP=4
  - next-PC select encoding: SEL_SEQ=2'd0, SEL_BR=2'd1, SEL_J=2'd2, SEL_JR=2'd3
- Sub-modules: instantiate the existing 32-bit adder Add twice, once for PC+4 (B=32'd4) and once for the branch target.
- Next-PC mux and IF/ID register stay in this module.

Test Plan:
1. Reset release with RESET_PC=0, imem returning addr^32'hA5A5_0000: PC steps 0, 4, 8 on successive edges; if_id_instr = 0xA5A5_0000 then 0xA5A5_0004, valid=1 from the first edge; if_id_pc4 = 4, 8.
2. Branch: if_id_pc4=0x0000_0010, branch_offset=0xFFFF_FFFE (−2), branch_taken=1 → branch_target_o=0x0000_0008; next pc=0x0000_0008; IF/ID valid=0 with instr=NOP for one cycle.
3. Jump plus simultaneous branch: if_id_pc4=0x4000_0010, jump_index=26'h000_0040, jump_i=1, branch_taken=1 → pc=0x4000_0100 (jump wins).
4. JR misaligned: jr_addr=0x0000_2003 → pc=0x0000_2000, misalign_o=1 for exactly one cycle.
5. Stall for 3 cycles with branch_taken=1: PC and IF/ID unchanged throughout; on the release edge pc = branch target. Also force pc=0xFFFF_FFFC → next pc=0x0000_0000.
6. Assert reset_n=0 asynchronously mid-cycle during a redirect: pc=RESET_PC and valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/mips_defs.sv
`timescale 1ps/100fs
// Shared MIPS fetch-stage constants and the next-PC select encoding.
package mips_defs;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } npc_sel_e;
endpackage

// File: rtl/fetch_pc_unit_add.sv
`timescale 1ps/100fs
// Gate-level ripple-carry adder; carry-out is discarded (modulo 2^W).
module Add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  logic [W-1:0] c;
  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
`timescale 1ps/100fs
// MIPS IF stage: program counter, next-PC selection and the IF/ID register.
module fetch_pc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic [31:0] branch_target_o,
  output logic        misalign_o
);
  logic [31:0] pc, pc4, br_tgt, npc, off_sh;
  npc_sel_e    sel;

  assign off_sh = branch_offset_i << 2;

  Add #(.W(32)) u_pc4 (.a(pc),          .b(PC_STEP), .sum(pc4));
  Add #(.W(32)) u_br  (.a(if_id_pc4_o), .b(off_sh),  .sum(br_tgt));

  assign imem_addr_o     = pc;
  assign branch_target_o = br_tgt;

  always_comb begin
    sel = SEL_SEQ;
    if      (jr_i)           sel = SEL_JR;
    else if (jump_i)         sel = SEL_J;
    else if (branch_taken_i) sel = SEL_BR;
  end

  always_comb begin
    npc = pc4;
    case (sel)
      SEL_JR:  npc = jr_addr_i & ~32'd3;
      SEL_J:   npc = {if_id_pc4_o[31:28], jump_index_i, 2'b00};
      SEL_BR:  npc = br_tgt;
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      if_id_pc4_o   <= '0;
      if_id_instr_o <= NOP_WORD;
      if_id_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      if (!stall_i) begin
        pc          <= npc;
        if_id_pc4_o <= pc4;
        // Any redirect squashes the wrong-path word fetched this cycle.
        if (sel == SEL_SEQ) begin
          if_id_instr_o <= imem_rdata_i;
          if_id_valid_o <= 1'b1;
        end else begin
          if_id_instr_o <= NOP_WORD;
          if_id_valid_o <= 1'b0;
        end
        misalign_o <= jr_i && (jr_addr_i[1:0] != 2'b00);
      end
      if (flush_i) begin
        if_id_instr_o <= NOP_WORD;
        if_id_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
`timescale 1ps/100fs
// Directed bench for fetch_pc_unit with a per-cycle reference model.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_i = 0, flush_i = 0, branch_taken_i = 0, jump_i = 0, jr_i = 0;
  logic [31:0] branch_offset_i = '0, jr_addr_i = '0;
  logic [25:0] jump_index_i = '0;
  logic [31:0] imem_addr_o, imem_rdata_i, if_id_pc4_o, if_id_instr_o, branch_target_o;
  logic        if_id_valid_o, misalign_o;

  int checks = 0;
  int errors = 0;

  always #2500 clk = ~clk;

  assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

  fetch_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
    .branch_taken_i(branch_taken_i), .branch_offset_i(branch_offset_i),
    .jump_i(jump_i), .jump_index_i(jump_index_i), .jr_i(jr_i), .jr_addr_i(jr_addr_i),
    .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .if_id_pc4_o(if_id_pc4_o), .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o), .branch_target_o(branch_target_o),
    .misalign_o(misalign_o)
  );

  // Reference model: architectural state only.
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_mis;

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] pc4r);
    longint unsigned t;
    if (jr_i)                return {jr_addr_i[31:2], 2'b00};
    if (jump_i)              return (pc4r & 32'hF000_0000) | ({6'd0, jump_index_i} * 4);
    if (branch_taken_i) begin
      t = longint'(pc4r) + longint'(branch_offset_i) * 4;
      return t[31:0];
    end
    t = longint'(pc) + 4;
    return t[31:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= 32'h0; m_pc4 <= 32'h0; m_instr <= 32'h0; m_valid <= 1'b0; m_mis <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      if (!stall_i) begin
        m_pc    <= next_pc(m_pc, m_pc4);
        m_pc4   <= m_pc + 32'd4;
        m_valid <= !(jr_i || jump_i || branch_taken_i) && !flush_i;
        m_instr <= (jr_i || jump_i || branch_taken_i || flush_i) ? 32'h0
                                                                 : (m_pc ^ 32'hA5A5_0000);
        m_mis   <= jr_i && (jr_addr_i % 4 != 0);
      end else if (flush_i) begin
        m_instr <= 32'h0;
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model comparison just before each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #4900;
      check32("cyc_pc",    imem_addr_o,           m_pc);
      check32("cyc_pc4",   if_id_pc4_o,           m_pc4);
      check32("cyc_instr", if_id_instr_o,         m_instr);
      check32("cyc_valid", {31'd0, if_id_valid_o}, {31'd0, m_valid});
      check32("cyc_mis",   {31'd0, misalign_o},    {31'd0, m_mis});
      check32("cyc_btgt",  branch_target_o,       m_pc4 + (branch_offset_i << 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1000;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] instr, input logic v);
    check32({tag, "_pc"},    imem_addr_o,            pc);
    check32({tag, "_pc4"},   if_id_pc4_o,            pc4);
    check32({tag, "_instr"}, if_id_instr_o,          instr);
    check32({tag, "_valid"}, {31'd0, if_id_valid_o}, {31'd0, v});
  endtask

  initial begin
    step(); step();
    chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    check32("rst_mis", {31'd0, misalign_o}, 32'd0);

    // Sequential fetch after reset release
    reset_n = 1'b1;
    step(); chk_if("seq1", 32'h4, 32'h4, 32'hA5A5_0000, 1'b1);
    step(); chk_if("seq2", 32'h8, 32'h8, 32'hA5A5_0004, 1'b1);
    step(); step(); chk_if("seq4", 32'h10, 32'h10, 32'hA5A5_000C, 1'b1);

    // Backward branch
    branch_taken_i = 1; branch_offset_i = 32'hFFFF_FFFE;
    #1 check32("br_tgt", branch_target_o, 32'h8);
    step(); chk_if("br", 32'h8, 32'h14, 32'h0, 1'b0);
    branch_taken_i = 0;
    step(); chk_if("br_after", 32'hC, 32'hC, 32'hA5A5_0008, 1'b1);

    // Jump beats a simultaneous branch
    jr_i = 1; jr_addr_i = 32'h4000_000C;
    step(); check32("jr_set", imem_addr_o, 32'h4000_000C);
    jr_i = 0;
    step(); chk_if("pre_j", 32'h4000_0010, 32'h4000_0010, 32'hE5A5_000C, 1'b1);
    jump_i = 1; jump_index_i = 26'h000_0040; branch_taken_i = 1; branch_offset_i = 32'h100;
    step(); check32("jump_pc", imem_addr_o, 32'h4000_0100);
    check32("jump_valid", {31'd0, if_id_valid_o}, 32'd0);
    jump_i = 0; branch_taken_i = 0;

    // Misaligned JR
    jr_i = 1; jr_addr_i = 32'h0000_2003;
    step(); check32("jrm_pc", imem_addr_o, 32'h2000);
    check32("jrm_mis", {31'd0, misalign_o}, 32'd1);
    jr_i = 0;
    step(); check32("jrm_mis_off", {31'd0, misalign_o}, 32'd0);
    chk_if("jrm_after", 32'h2004, 32'h2004, 32'hA5A5_2000, 1'b1);

    // Stall with pending branch
    stall_i = 1; branch_taken_i = 1; branch_offset_i = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step(); chk_if("stall", 32'h2004, 32'h2004, 32'hA5A5_2000, 1'b1);
    end
    stall_i = 0;
    step(); check32("stall_rel_pc", imem_addr_o, 32'h2014);
    check32("stall_rel_valid", {31'd0, if_id_valid_o}, 32'd0);
    branch_taken_i = 0;

    // PC wrap
    jr_i = 1; jr_addr_i = 32'hFFFF_FFFC;
    step(); check32("wrap_set", imem_addr_o, 32'hFFFF_FFFC);
    jr_i = 0;
    step(); chk_if("wrap", 32'h0, 32'h0, 32'h5A5A_FFFC, 1'b1);

    // Flush, then flush together with stall
    flush_i = 1;
    step(); chk_if("flush", 32'h4, 32'h4, 32'h0, 1'b0);
    stall_i = 1;
    step(); chk_if("flush_stall", 32'h4, 32'h4, 32'h0, 1'b0);
    flush_i = 0; stall_i = 0;
    step(); chk_if("flush_after", 32'h8, 32'h8, 32'hA5A5_0004, 1'b1);

    // Asynchronous reset in the middle of a redirect
    jump_i = 1; jump_index_i = 26'h123;
    #1000 reset_n = 0;
    #1 chk_if("arst", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); check32("arst_hold", imem_addr_o, 32'h0);
    jump_i = 0; reset_n = 1;
    step(); chk_if("arst_rel", 32'h4, 32'h4, 32'hA5A5_0000, 1'b1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
